// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel input conditioner for push buttons, bumpers
// and limit switches. Each channel is synchronised, debounced and
// polarity-corrected. It produces registered press and release pulses and
// also flags a long press.
module debounce_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  STABLE_CYCLES = 500000,
  parameter int                  LONG_CYCLES   = 50000000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] long_held
);

  // Debounce counter only needs to reach STABLE_CYCLES-1. The hold counter
  // saturates at LONG_CYCLES.
  localparam int              DW        = $clog2(STABLE_CYCLES);
  localparam int              HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0]   DEB_LAST  = DW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(LONG_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic          s1_reg;
      logic          s2_reg;
      logic          level_reg;
      logic          rise_reg;
      logic          fall_reg;
      logic          long_pulse_reg;
      logic          long_held_reg;
      logic [DW-1:0] deb_cnt_reg;
      logic [HW-1:0] hold_cnt_reg;
      logic          accept;
      logic          falling;

      // A new s2 value is accepted once it has differed from level for
      // STABLE_CYCLES consecutive cycles.
      always_comb begin
        accept  = (s2_reg != level_reg) && (deb_cnt_reg == DEB_LAST);
        falling = accept && level_reg;
      end

      // Two-flop synchroniser. Polarity is corrected before the first stage,
      // so reset loads the inactive value 0 into both stages.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw_in[gi] ^ ACTIVE_LOW[gi];
          s2_reg <= s1_reg;
        end
      end

      // Debounce counter. Any return of s2 to level discards progress.
      // rise and fall are registered alongside the level toggle.
      always_ff @(posedge clk) begin
        if (rst) begin
          deb_cnt_reg <= '0;
          level_reg   <= 1'b0;
          rise_reg    <= 1'b0;
          fall_reg    <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          if (s2_reg == level_reg) begin
            deb_cnt_reg <= '0;
          end else if (accept) begin
            deb_cnt_reg <= '0;
            level_reg   <= s2_reg;
            rise_reg    <= s2_reg;
            fall_reg    <= ~s2_reg;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
          end
        end
      end

      // Long-press timer. It counts while level is high and saturates at
      // LONG_CYCLES, so a held input fires long_pulse only once. It clears on
      // the falling edge, so long_held drops in the same cycle as fall.
      always_ff @(posedge clk) begin
        if (rst) begin
          hold_cnt_reg   <= '0;
          long_pulse_reg <= 1'b0;
          long_held_reg  <= 1'b0;
        end else begin
          long_pulse_reg <= 1'b0;
          if (!level_reg || falling) begin
            hold_cnt_reg  <= '0;
            long_held_reg <= 1'b0;
          end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
            if (hold_cnt_reg == HOLD_LAST) begin
              long_pulse_reg <= 1'b1;
              long_held_reg  <= 1'b1;
            end
          end
        end
      end

      assign level[gi]      = level_reg;
      assign rise[gi]       = rise_reg;
      assign fall[gi]       = fall_reg;
      assign long_pulse[gi] = long_pulse_reg;
      assign long_held[gi]  = long_held_reg;
    end
  endgenerate

endmodule
